// File: rtl/rf_pkg.sv
// Shared definitions for the register-file command sequencer: opcodes, FSM
// state encoding, default widths and the illegal-opcode response byte.
package rf_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_MOV    = 4'h1;
  localparam logic [3:0] OP_GET    = 4'h2;
  localparam logic [3:0] OP_ACC    = 4'h3;
  localparam logic [3:0] OP_CLRERR = 4'h4;

  localparam logic [7:0] ERR_RSP = 8'hFF;

  typedef enum logic [3:0] {
    StIdle,
    StWaitImm,
    StWaitDst,
    StRdA,
    StCap,
    StRdB,
    StAdd,
    StWr,
    StRsp
  } state_e;

endpackage

// File: rtl/rf_16x8.sv
// Register file storage: one synchronous read port and one write port sharing
// a single address, cleared to zero by asynchronous reset.
module rf_16x8
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write on we_i; read data registered every cycle (old data on a write cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rf_cmd_sequencer.sv
// Byte-serial command front end sequencing read, write and accumulate accesses
// to an external synchronous-read register file.
// Optional macro RF_SAT_EN: accumulate saturates at all-ones instead of wrapping.
module rf_cmd_sequencer
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_byte,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              err,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  state_e            state_q;
  logic              cmd_ready_q, rsp_valid_q, err_q, rf_we_q, acc_q;
  logic [DATA_W-1:0] rsp_data_q, rf_wdata_q, a_q, acc_sum;
  logic [ADDR_W-1:0] rf_addr_q, src_q, dst_q;
  logic [3:0]        op;
  logic [ADDR_W-1:0] nib;
  logic              accept;

  assign op     = cmd_byte[3:0];
  assign nib    = cmd_byte[4 +: ADDR_W];
  assign accept = cmd_valid && cmd_ready_q;

  // Accumulate result: operand A was latched in RD_B, operand B is on rf_rdata in ADD.
`ifdef RF_SAT_EN
  logic [DATA_W:0] sum_wide;
  always_comb begin
    sum_wide = {1'b0, a_q} + {1'b0, rf_rdata};
    acc_sum  = sum_wide[DATA_W] ? '1 : sum_wide[DATA_W-1:0];
  end
`else
  always_comb begin
    acc_sum = a_q + rf_rdata;
  end
`endif

  // Command FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      rf_addr_q   <= '0;
      rf_we_q     <= 1'b0;
      rf_wdata_q  <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      acc_q       <= 1'b0;
      a_q         <= '0;
    end else begin
      // Write strobe is a single-cycle pulse, raised only on entry to WR.
      rf_we_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            case (op)
              OP_NOP: ;
              OP_MOV: begin
                dst_q   <= nib;
                state_q <= StWaitImm;
              end
              OP_GET: begin
                src_q       <= nib;
                acc_q       <= 1'b0;
                rf_addr_q   <= nib;
                cmd_ready_q <= 1'b0;
                state_q     <= StRdA;
              end
              OP_ACC: begin
                src_q   <= nib;
                acc_q   <= 1'b1;
                state_q <= StWaitDst;
              end
              OP_CLRERR: err_q <= 1'b0;
              default: begin
                err_q       <= 1'b1;
                rsp_data_q  <= DATA_W'(ERR_RSP);
                rsp_valid_q <= 1'b1;
                cmd_ready_q <= 1'b0;
                state_q     <= StRsp;
              end
            endcase
          end
        end
        StWaitImm: begin
          if (accept) begin
            rf_we_q     <= 1'b1;
            rf_addr_q   <= dst_q;
            rf_wdata_q  <= cmd_byte[DATA_W-1:0];
            cmd_ready_q <= 1'b0;
            state_q     <= StWr;
          end
        end
        StWaitDst: begin
          if (accept) begin
            dst_q       <= cmd_byte[ADDR_W-1:0];
            rf_addr_q   <= src_q;
            cmd_ready_q <= 1'b0;
            state_q     <= StRdA;
          end
        end
        StRdA: begin
          if (acc_q) begin
            rf_addr_q <= dst_q;
            state_q   <= StRdB;
          end else begin
            state_q <= StCap;
          end
        end
        StCap: begin
          rsp_data_q  <= rf_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= StRsp;
        end
        StRdB: begin
          a_q     <= rf_rdata;
          state_q <= StAdd;
        end
        StAdd: begin
          rf_we_q    <= 1'b1;
          rf_addr_q  <= dst_q;
          rf_wdata_q <= acc_sum;
          state_q    <= StWr;
        end
        StWr: begin
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign rf_addr   = rf_addr_q;
  assign rf_we     = rf_we_q;
  assign rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// Scoreboard bench for rf_cmd_sequencer with the rf_16x8 storage alongside it.
module tb_rf_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, rf_rst_n;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, err, rf_we;
  logic [7:0] cmd_byte, rsp_data, rf_wdata, rf_rdata;
  logic [3:0] rf_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] wr_q[$];   // expected writes {addr, data}
  logic [7:0]  rsp_q[$];  // expected response bytes
  logic [7:0]  model_rf[16];

  always #5 clk = ~clk;

  rf_cmd_sequencer #(.DATA_W(8), .ADDR_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_byte  (cmd_byte),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .err       (err),
    .rf_addr   (rf_addr),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata)
  );

  // Storage has its own reset so a sequencer reset leaves register contents intact.
  rf_16x8 #(.DATA_W(8), .ADDR_W(4)) u_rf (
    .clk     (clk),
    .rst_n   (rf_rst_n),
    .addr_i  (rf_addr),
    .we_i    (rf_we),
    .wdata_i (rf_wdata),
    .rdata_o (rf_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] acc_model(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef RF_SAT_EN
    if (s > 255) s = 255;
`endif
    return s[7:0];
  endfunction

  // Output monitor: every write pulse and response handshake must match the queue head.
  always @(negedge clk) begin
    #1;
    if (rst_n && rf_we) begin
      if (wr_q.size() == 0) begin
        check_eq("unexpected_write", 32'(wr_q.size()), 32'd1);
      end else begin
        logic [11:0] e;
        e = wr_q.pop_front();
        check_eq("wr_addr", 32'(rf_addr), 32'(e[11:8]));
        check_eq("wr_data", 32'(rf_wdata), 32'(e[7:0]));
      end
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        check_eq("unexpected_rsp", 32'(rsp_q.size()), 32'd1);
      end else begin
        check_eq("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
      end
    end
  end

  // Offer one byte; returns just after the edge on which it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    #1;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) check_eq("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Count negedges after acceptance until rf_we is seen.
  task automatic wait_we(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!rf_we && n < 30);
    if (!rf_we) check_eq("we_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!rsp_valid && n < 30);
    if (!rsp_valid) check_eq("rsp_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_mov(input logic [3:0] r, input logic [7:0] v);
    int n;
    wr_q.push_back({r, v});
    model_rf[r] = v;
    send_byte({r, 4'h1});
    send_byte(v);
    wait_we(n);
  endtask

  task automatic do_acc(input logic [3:0] s, input logic [3:0] d);
    int n;
    logic [7:0] v;
    v = acc_model(model_rf[s], model_rf[d]);
    wr_q.push_back({d, v});
    model_rf[d] = v;
    send_byte({s, 4'h3});
    send_byte({4'h0, d});
    wait_we(n);
  endtask

  task automatic do_get(input logic [3:0] r);
    int n;
    rsp_q.push_back(model_rf[r]);
    send_byte({r, 4'h2});
    wait_rsp(n);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) model_rf[i] = 8'h00;
    rst_n = 1'b0; rf_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_byte = 8'h00; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_rf_addr", 32'(rf_addr), 32'd0);
    check_eq("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rf_rst_n = 1'b1;

    // MOV r5,0x3C: write one cycle after the immediate byte.
    wr_q.push_back({4'd5, 8'h3C});
    model_rf[5] = 8'h3C;
    send_byte(8'h51);
    send_byte(8'h3C);
    wait_we(n);
    check_eq("mov_latency", 32'(n), 32'd1);

    // GET r5: response valid on the third cycle after the byte.
    rsp_q.push_back(8'h3C);
    send_byte(8'h52);
    wait_rsp(n);
    check_eq("get_latency", 32'(n), 32'd3);
    check_eq("get_data", 32'(rsp_data), 32'h3C);
    @(negedge clk);

    do_mov(4'd1, 8'h10);
    do_mov(4'd2, 8'h25);
    do_acc(4'd1, 4'd2);
    do_get(4'd2);

    do_mov(4'd3, 8'hF0);
    do_mov(4'd4, 8'h20);
    do_acc(4'd3, 4'd4);
    do_get(4'd4);

    // src == dst doubles the register.
    do_mov(4'd6, 8'h21);
    do_acc(4'd6, 4'd6);
    do_get(4'd6);

    // Illegal opcode: 0xFF response and sticky err until CLRERR.
    rsp_q.push_back(8'hFF);
    send_byte(8'h0F);
    check_eq("err_set", 32'(err), 32'd1);
    wait_rsp(n);
    @(negedge clk);
    send_byte(8'h00);
    check_eq("err_sticky_nop", 32'(err), 32'd1);
    send_byte(8'h04);
    check_eq("err_cleared", 32'(err), 32'd0);

    // Response backpressure: held output, no command bytes consumed.
    rsp_ready = 1'b0;
    rsp_q.push_back(model_rf[5]);
    send_byte(8'h52);
    wait_rsp(n);
    cmd_valid = 1'b1;
    cmd_byte  = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_rsp_data", 32'(rsp_data), 32'(model_rf[5]));
      check_eq("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("stall_no_consume_err", 32'(err), 32'd0);
    check_eq("stall_released", 32'(rsp_valid), 32'd0);

    // Reset asserted while ACC is in ADD: no write, register unchanged.
    do_mov(4'd7, 8'h11);
    do_mov(4'd8, 8'h22);
    send_byte(8'h73);
    send_byte(8'h08);
    repeat (3) @(negedge clk);   // RD_A, RD_B, ADD
    rst_n = 1'b0;
    #1;
    check_eq("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("midrst_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    #1;
    check_eq("midrst_rf_we_next", 32'(rf_we), 32'd0);
    rst_n = 1'b1;
    do_get(4'd8);

    repeat (3) @(negedge clk);
    check_eq("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    check_eq("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
